// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM pipeline register: entry layout, state encoding
// and the branch-resolution helper.
package ex_mem_pkg;

    // Widest datapath and register index an entry can carry; the top-level
    // XLEN / RD_W parameters must not exceed these.
    localparam int EX_XLEN_MAX = 64;
    localparam int EX_RD_W_MAX = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [EX_XLEN_MAX-1:0] result;
        logic [EX_XLEN_MAX-1:0] store_data;
        logic [EX_RD_W_MAX-1:0] rd;
        logic                   reg_write;
        logic                   mem_read;
        logic                   mem_write;
        logic                   branch_taken;
    } entry_t;

    // beq is taken on zero, bne on non-zero; non-branches are never taken.
    function automatic logic branch_taken_f(input logic branch,
                                            input logic alu_zero,
                                            input logic branch_ne);
        return branch & (alu_zero ^ branch_ne);
    endfunction

endpackage

// File: rtl/ex_mem_skid2.sv
// Two-entry FIFO holding EX/MEM entries. Outputs come straight from the head
// register, which is cleared whenever the buffer becomes empty.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | no entry held, out_valid low, head reads 0
// ST_ONE   | head valid, tail unused
// ST_TWO   | head and tail valid, in_ready low
module ex_mem_skid2
    import ex_mem_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   in_valid,
    output logic   in_ready,
    input  entry_t in_entry,
    output logic   out_valid,
    input  logic   out_ready,
    output entry_t out_entry
);

    state_t state;
    entry_t head;
    entry_t tail;

    // Handshake flags depend only on the registered state, never on out_ready.
    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign out_entry = head;

    // FIFO control: reset and flush empty both slots; otherwise accept/drain.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= ST_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        head  <= in_entry;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_valid && out_ready) begin
                        head <= in_entry;
                    end else if (in_valid) begin
                        tail  <= in_entry;
                        state <= ST_TWO;
                    end else if (out_ready) begin
                        head  <= '0;
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_ready) begin
                        head  <= tail;
                        tail  <= '0;
                        state <= ST_ONE;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                    head  <= '0;
                    tail  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: resolves the branch at accept time and buffers up
// to two entries toward the memory stage.
// Optional: define EX_MEM_PERF_CNT_EN to add the stall_cycles counter output.
module ex_mem_reg
    import ex_mem_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            branch,
    input  logic            branch_ne,
    input  logic [RD_W-1:0] rd,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [XLEN-1:0] store_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef EX_MEM_PERF_CNT_EN
    output logic [31:0]     stall_cycles,
`endif
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [RD_W-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch_taken
);

    entry_t in_entry;
    entry_t head;

    // Pack the incoming entry, zero-extending narrow fields into the shared layout.
    always_comb begin
        in_entry                   = '0;
        in_entry.result[XLEN-1:0]  = alu_result;
        in_entry.store_data[XLEN-1:0] = store_data;
        in_entry.rd[RD_W-1:0]      = rd;
        in_entry.reg_write         = reg_write;
        in_entry.mem_read          = mem_read;
        in_entry.mem_write         = mem_write;
        in_entry.branch_taken      = branch_taken_f(branch, alu_zero, branch_ne);
    end

    ex_mem_skid2 u_skid2 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_entry  (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_entry (head)
    );

    assign out_result       = head.result[XLEN-1:0];
    assign out_store_data   = head.store_data[XLEN-1:0];
    assign out_rd           = head.rd[RD_W-1:0];
    assign out_reg_write    = head.reg_write;
    assign out_mem_read     = head.mem_read;
    assign out_mem_write    = head.mem_write;
    assign out_branch_taken = head.branch_taken;

`ifdef EX_MEM_PERF_CNT_EN
    // Count cycles the memory stage back-pressures a valid head; saturates, reset-only clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
